// File: rtl/skywater_lvlshift_pkg.sv
// Shared types and sizing helpers for the level-shifter bank.
package skywater_lvlshift_pkg;

    typedef enum logic [1:0] {
        ST_ISO      = 2'd0,
        ST_DEBOUNCE = 2'd1,
        ST_SETTLE   = 2'd2,
        ST_ACTIVE   = 2'd3
    } lvl_state_t;

    // Bits needed for a counter that must hold the value max_val itself.
    function automatic int cnt_width(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

    localparam int DEB_CYCLES_MAX = 255;
    localparam int DEB_CNT_W_MAX  = cnt_width(DEB_CYCLES_MAX);

endpackage

// File: rtl/skywater_lvlshift_sync.sv
// Multi-flop bit synchroniser with async reset and synchronous flush.
module skywater_lvlshift_sync
    import skywater_lvlshift_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rstb,
    input  logic clr,
    input  logic d,
    output logic q
);

    logic [SYNC_STAGES-1:0] ff;

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            ff <= '0;
        end else if (clr) begin
            ff <= '0;
        end else begin
            ff <= {ff[SYNC_STAGES-2:0], d};
        end
    end

    assign q = ff[SYNC_STAGES-1];

endmodule

// File: rtl/skywater_lvlshift_bank.sv
// Bank of synchronised level-shift channels with supply-aware isolation FSM.
module skywater_lvlshift_bank
    import skywater_lvlshift_pkg::*;
#(
    parameter int                NUM_CH      = 8,
    parameter int                SYNC_STAGES = 2,
    parameter int                DEB_CYCLES  = 4,
    parameter logic [NUM_CH-1:0] CLAMP_VAL   = '0
) (
    input  logic              clk,
    input  logic              rstb,
    input  logic [NUM_CH-1:0] in,
    input  logic [NUM_CH-1:0] en,
    input  logic              vdd_in_ok,
    input  logic              iso_req,
    output logic [NUM_CH-1:0] out,
    output logic              iso_ack,
    output logic              ready
);

    localparam int DEB_W = cnt_width(DEB_CYCLES);
    localparam int SET_W = cnt_width(SYNC_STAGES);
    localparam logic [DEB_W-1:0] DEB_MAX  = DEB_W'(DEB_CYCLES);
    localparam logic [SET_W-1:0] SET_LAST = SET_W'(SYNC_STAGES - 1);

    lvl_state_t        state, state_nxt;
    logic              sup_ok;
    logic              data_clr;
    logic [NUM_CH-1:0] data_sync;
    logic [DEB_W-1:0]  deb_cnt, deb_cnt_nxt;
    logic [SET_W-1:0]  set_cnt, set_cnt_nxt;

    skywater_lvlshift_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sup_sync (
        .clk  (clk),
        .rstb (rstb),
        .clr  (1'b0),
        .d    (vdd_in_ok),
        .q    (sup_ok)
    );

    // Data synchronisers are held empty while isolated so SETTLE starts clean.
    assign data_clr = (state == ST_ISO);

    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
        skywater_lvlshift_sync #(.SYNC_STAGES(SYNC_STAGES)) u_data_sync (
            .clk  (clk),
            .rstb (rstb),
            .clr  (data_clr),
            .d    (in[gi]),
            .q    (data_sync[gi])
        );
    end

    always_comb begin
        state_nxt   = state;
        deb_cnt_nxt = '0;
        set_cnt_nxt = '0;
        // Loss of supply or an isolation request overrides every other move.
        if (state != ST_ISO && (!sup_ok || iso_req)) begin
            state_nxt = ST_ISO;
        end else begin
            case (state)
                ST_ISO: begin
                    if (sup_ok && !iso_req) state_nxt = ST_DEBOUNCE;
                end
                ST_DEBOUNCE: begin
                    deb_cnt_nxt = (deb_cnt < DEB_MAX) ? deb_cnt + 1'b1 : deb_cnt;
                    if (deb_cnt_nxt == DEB_MAX) state_nxt = ST_SETTLE;
                end
                ST_SETTLE: begin
                    set_cnt_nxt = set_cnt + 1'b1;
                    if (set_cnt == SET_LAST) state_nxt = ST_ACTIVE;
                end
                ST_ACTIVE: ;
                default: state_nxt = ST_ISO;
            endcase
        end
    end

    // Status and outputs follow the next state so isolation clamps on the same edge.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state   <= ST_ISO;
            deb_cnt <= '0;
            set_cnt <= '0;
            iso_ack <= 1'b1;
            ready   <= 1'b0;
            out     <= CLAMP_VAL;
        end else begin
            state   <= state_nxt;
            deb_cnt <= deb_cnt_nxt;
            set_cnt <= set_cnt_nxt;
            iso_ack <= (state_nxt == ST_ISO);
            ready   <= (state_nxt == ST_ACTIVE);
            out     <= (state_nxt == ST_ACTIVE) ? ((data_sync & en) | (CLAMP_VAL & ~en))
                                                : CLAMP_VAL;
        end
    end

endmodule

// File: tb/tb_skywater_lvlshift_bank.sv
// Randomised self-checking bench for skywater_lvlshift_bank against a run-length reference model.
module tb_skywater_lvlshift_bank;

    localparam int         NUM_CH    = 8;
    localparam int         SS        = 2;
    localparam int         DEB       = 4;
    localparam logic [7:0] CLAMP     = 8'hA5;
    localparam int         RUN_READY = 1 + DEB + SS;

    logic       clk = 1'b0;
    logic       rstb;
    logic [7:0] din, den;
    logic       vdd_in_ok, iso_req;
    logic [7:0] out;
    logic       iso_ack, ready;

    int errors = 0;
    int checks = 0;

    // Reference model: ready after RUN_READY consecutive edges with supply good and no request.
    int         run;
    logic       vq [SS];
    logic [7:0] dq [SS];
    logic [7:0] exp_out;
    logic       exp_ready, exp_iso;

    always #5 clk = ~clk;

    skywater_lvlshift_bank #(
        .NUM_CH      (NUM_CH),
        .SYNC_STAGES (SS),
        .DEB_CYCLES  (DEB),
        .CLAMP_VAL   (CLAMP)
    ) dut (
        .clk       (clk),
        .rstb      (rstb),
        .in        (din),
        .en        (den),
        .vdd_in_ok (vdd_in_ok),
        .iso_req   (iso_req),
        .out       (out),
        .iso_ack   (iso_ack),
        .ready     (ready)
    );

    task automatic model_reset();
        run = 0;
        for (int i = 0; i < SS; i++) begin
            vq[i] = 1'b0;
            dq[i] = 8'h00;
        end
        exp_out   = CLAMP;
        exp_ready = 1'b0;
        exp_iso   = 1'b1;
    endtask

    task automatic tick();
        logic       sup;
        logic [7:0] data;
        @(posedge clk);
        sup  = vq[SS-1];
        data = dq[SS-1];
        for (int i = SS - 1; i > 0; i--) begin
            vq[i] = vq[i-1];
            dq[i] = dq[i-1];
        end
        vq[0] = vdd_in_ok;
        dq[0] = din;
        if (sup && !iso_req) run = (run < RUN_READY) ? run + 1 : run;
        else                 run = 0;
        exp_ready = (run >= RUN_READY);
        exp_iso   = (run == 0);
        exp_out   = exp_ready ? ((data & den) | (CLAMP & ~den)) : CLAMP;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rstb = 1'b0; vdd_in_ok = 1'b1; iso_req = 1'b0; den = 8'hFF; din = 8'h3C;
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if (out !== CLAMP) begin
            errors++; $display("FAIL reset_out: got %h want %h", out, CLAMP);
        end
        checks++;
        if (ready !== 1'b0) begin
            errors++; $display("FAIL reset_ready: got %b want 0", ready);
        end
        checks++;
        if (iso_ack !== 1'b1) begin
            errors++; $display("FAIL reset_iso_ack: got %b want 1", iso_ack);
        end
    endtask

    task automatic test_power_up();
        int first_rdy = 0;
        rstb = 1'b1;
        for (int n = 1; n <= 14; n++) begin
            din = 8'($urandom);
            tick();
            checks++;
            if ({out, ready, iso_ack} !== {exp_out, exp_ready, exp_iso}) begin
                errors++;
                $display("FAIL pwrup cyc %0d: out=%h ready=%b iso_ack=%b want out=%h ready=%b iso_ack=%b",
                         n, out, ready, iso_ack, exp_out, exp_ready, exp_iso);
            end
            if (ready === 1'b1 && first_rdy == 0) first_rdy = n;
        end
        checks++;
        if (first_rdy != 9) begin
            errors++; $display("FAIL pwrup_latency: ready at cycle %0d want 9", first_rdy);
        end
    endtask

    task automatic test_random_traffic();
        for (int n = 0; n < 40; n++) begin
            din = 8'($urandom);
            den = 8'($urandom);
            tick();
            checks++;
            if ({out, ready, iso_ack} !== {exp_out, exp_ready, exp_iso}) begin
                errors++;
                $display("FAIL traffic cyc %0d: out=%h ready=%b iso_ack=%b want out=%h ready=%b iso_ack=%b",
                         n, out, ready, iso_ack, exp_out, exp_ready, exp_iso);
            end
        end
    endtask

    task automatic test_enable();
        din = 8'hFF; den = 8'hFF;
        repeat (3) tick();
        den = 8'h0F;
        tick();
        checks++;
        if (out !== 8'hAF) begin
            errors++; $display("FAIL enable_0f: got %h want af", out);
        end
        den = 8'hFF;
        tick();
        checks++;
        if (out !== 8'hFF || ready !== 1'b1) begin
            errors++; $display("FAIL enable_ff: got out=%h ready=%b want out=ff ready=1", out, ready);
        end
    endtask

    task automatic test_supply_drop();
        vdd_in_ok = 1'b0;
        tick(); tick();
        checks++;
        if (ready !== 1'b1) begin
            errors++; $display("FAIL drop_sync_delay: ready=%b want 1", ready);
        end
        tick();
        checks++;
        if ({out, ready, iso_ack} !== {CLAMP, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL drop_clamp: out=%h ready=%b iso_ack=%b want out=%h ready=0 iso_ack=1",
                     out, ready, iso_ack, CLAMP);
        end
        repeat (4) tick();
    endtask

    task automatic test_glitch();
        vdd_in_ok = 1'b1;
        repeat (3) tick();
        vdd_in_ok = 1'b0;
        for (int n = 0; n < 12; n++) begin
            din = 8'($urandom);
            tick();
            checks++;
            if (ready !== 1'b0 || out !== CLAMP || exp_ready !== 1'b0) begin
                errors++;
                $display("FAIL glitch cyc %0d: out=%h ready=%b want out=%h ready=0", n, out, ready, CLAMP);
            end
        end
        checks++;
        if (iso_ack !== 1'b1) begin
            errors++; $display("FAIL glitch_iso: iso_ack=%b want 1", iso_ack);
        end
    endtask

    task automatic test_iso_req();
        int lat = 0;
        vdd_in_ok = 1'b1;
        repeat (12) tick();
        checks++;
        if (ready !== 1'b1) begin
            errors++; $display("FAIL isoreq_pre: ready=%b want 1", ready);
        end
        iso_req = 1'b1;
        tick();
        checks++;
        if (iso_ack !== 1'b1 || ready !== 1'b0) begin
            errors++; $display("FAIL isoreq_ack: iso_ack=%b ready=%b want 1/0", iso_ack, ready);
        end
        iso_req = 1'b0;
        while (ready !== 1'b1 && lat < 40) begin
            tick();
            lat++;
        end
        checks++;
        if (lat != DEB + SS + 1) begin
            errors++; $display("FAIL isoreq_recover: latency %0d want %0d", lat, DEB + SS + 1);
        end
    endtask

    task automatic test_back_to_back();
        vdd_in_ok = 1'b0; iso_req = 1'b1;
        tick();
        checks++;
        if (iso_ack !== 1'b1 || ready !== 1'b0 || out !== CLAMP) begin
            errors++; $display("FAIL dual_iso: iso_ack=%b ready=%b out=%h want 1/0/%h", iso_ack, ready, out, CLAMP);
        end
        for (int n = 0; n < 300; n++) begin
            vdd_in_ok = ($urandom_range(0, 19) != 0);
            iso_req   = ($urandom_range(0, 29) == 0);
            din       = 8'($urandom);
            den       = 8'($urandom);
            tick();
            checks++;
            if ({out, ready, iso_ack} !== {exp_out, exp_ready, exp_iso}) begin
                errors++;
                $display("FAIL mixed cyc %0d: out=%h ready=%b iso_ack=%b want out=%h ready=%b iso_ack=%b",
                         n, out, ready, iso_ack, exp_out, exp_ready, exp_iso);
            end
        end
    endtask

    task automatic test_async_reset();
        vdd_in_ok = 1'b1; iso_req = 1'b0; den = 8'hFF; din = 8'h5A;
        repeat (12) tick();
        checks++;
        if (ready !== 1'b1 || out !== 8'h5A) begin
            errors++; $display("FAIL arst_pre: ready=%b out=%h want 1/5a", ready, out);
        end
        #2 rstb = 1'b0;
        #1;
        checks++;
        if ({out, ready, iso_ack} !== {CLAMP, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL arst_clamp: out=%h ready=%b iso_ack=%b want out=%h ready=0 iso_ack=1",
                     out, ready, iso_ack, CLAMP);
        end
        model_reset();
        @(negedge clk);
        rstb = 1'b1;
        for (int n = 0; n < 12; n++) begin
            din = 8'($urandom);
            tick();
            checks++;
            if ({out, ready, iso_ack} !== {exp_out, exp_ready, exp_iso}) begin
                errors++;
                $display("FAIL arst_recover cyc %0d: out=%h ready=%b iso_ack=%b want out=%h ready=%b iso_ack=%b",
                         n, out, ready, iso_ack, exp_out, exp_ready, exp_iso);
            end
        end
    endtask

    initial begin
        test_reset();
        test_power_up();
        test_random_traffic();
        test_enable();
        test_supply_drop();
        test_glitch();
        test_iso_req();
        test_back_to_back();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
